// File: rtl/comp_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: FSM states and
// one-hot {eq,lt,gt} result codes.
package comp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Result codes are packed as {eq, lt, gt}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  // A differing sign bit means the opposite ordering in two's complement.
  function automatic logic [2:0] swap_lt_gt(input logic [2:0] res);
    return {res[2], res[0], res[1]};
  endfunction

endpackage

// File: rtl/comp_cell.sv
// Single-bit magnitude compare cell: one-hot eq/lt/gt for one bit pair.
module comp_cell (
  input  logic a_i,
  input  logic b_i,
  output logic eq_o,
  output logic lt_o,
  output logic gt_o
);

  assign eq_o = (a_i == b_i);
  assign lt_o = ~a_i & b_i;
  assign gt_o = a_i & ~b_i;

endmodule

// File: rtl/seq_mag_comp.sv
// Bit-serial WIDTH-bit magnitude comparator: scans latched operands MSB-first
// through one comp_cell and stops at the first differing bit.
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       res_q, res_d;

  logic       cell_eq, cell_lt, cell_gt;
  logic [2:0] cell_res;

  comp_cell u_cell (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .eq_o (cell_eq),
    .lt_o (cell_lt),
    .gt_o (cell_gt)
  );

  assign cell_res = {cell_eq, cell_lt, cell_gt};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_MSB;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!cell_eq) begin
          res_d   = (SIGNED && (idx_q == IDX_MSB)) ? swap_lt_gt(cell_res) : cell_res;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          res_d   = RES_NONE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        res_d   = RES_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign eq        = res_q[2];
  assign lt        = res_q[1];
  assign gt        = res_q[0];

endmodule
